mips_mc_control: RTL and testbench

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_mc_control.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// mips_mc_control -- multicycle MIPS control unit.
// Moore FSM sequencing fetch/decode/execute/memory/writeback for R-type,
// lw, sw, addi, beq, bne and j. Unrecognised opcodes are treated as NOPs.
// Optional feature macro OVF_TRAP_EN: when defined, a signed overflow on
// add/sub/addi suppresses the register writeback and raises ovf_exc for
// one cycle; when undefined, writeback is unconditional and ovf_exc is 0.
module mips_mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       overflow,
    output logic [3:0] ALUControl,
    output logic       ALUSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       IorD,
    output logic [1:0] PCSrc,
    output logic       ovf_exc
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function fields
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDU = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;
    localparam logic [3:0] ALU_BNE  = 4'b1010;

    // PC source select
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_EXEC_I = 4'd8,
        S_WB_I   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [3:0] w_funct_alu;
    logic       w_funct_valid;
    logic       w_ovf_trap;

    logic [3:0] w_alu_control;
    logic       w_alu_src;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_i_or_d;
    logic [1:0] w_pc_src;
    logic       w_ovf_exc;

    // Translate the R-type funct field into an ALU op; unknown functs fall back to ADD and are flagged invalid
    always_comb begin
        w_funct_alu   = ALU_ADD;
        w_funct_valid = 1'b1;
        case (funct)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_ADDU: w_funct_alu = ALU_ADDU;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_SUBU: w_funct_alu = ALU_SUBU;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_SLL:  w_funct_alu = ALU_SLL;
            FN_SRL:  w_funct_alu = ALU_SRL;
            FN_SLT:  w_funct_alu = ALU_SLT;
            default: begin
                w_funct_alu   = ALU_ADD;
                w_funct_valid = 1'b0;
            end
        endcase
    end

    // State register; reset returns to FETCH and abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef OVF_TRAP_EN
    logic r_ovf_flag;

    // Capture overflow at the end of signed add/sub execution; clear it on FETCH and non-trapping R ops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_flag <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:  r_ovf_flag <= 1'b0;
                S_EXEC_R: r_ovf_flag <= ((w_funct_alu == ALU_ADD) || (w_funct_alu == ALU_SUB)) ? overflow : 1'b0;
                S_EXEC_I: r_ovf_flag <= overflow;
                default:  r_ovf_flag <= r_ovf_flag;
            endcase
        end
    end

    assign w_ovf_trap = r_ovf_flag;
`else
    // Without the trap feature the overflow flag is ignored and writeback always happens
    logic w_unused_overflow;
    assign w_unused_overflow = overflow;
    assign w_ovf_trap        = 1'b0;
`endif

    // Next-state and Moore output decode; every control defaults to 0 and ALUControl to ADD
    always_comb begin
        w_next_state  = r_state;
        w_alu_control = ALU_ADD;
        w_alu_src     = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_i_or_d      = 1'b0;
        w_pc_src      = PC_PLUS4;
        w_ovf_exc     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_write   = 1'b1;
                w_pc_src     = PC_PLUS4;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      w_next_state = S_EXEC_R;
                    OP_LW, OP_SW:  w_next_state = S_MEMADR;
                    OP_ADDI:       w_next_state = S_EXEC_I;
                    OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
                    OP_J:          w_next_state = S_JUMP;
                    default:       w_next_state = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                w_alu_control = w_funct_alu;
                w_alu_src     = 1'b0;
                w_next_state  = S_WB_R;
            end
            S_WB_R: begin
                w_reg_write  = w_funct_valid && !w_ovf_trap;
                w_reg_dst    = 1'b1;
                w_mem_to_reg = 1'b0;
                w_ovf_exc    = w_ovf_trap;
                w_next_state = S_FETCH;
            end
            S_MEMADR: begin
                w_alu_control = ALU_ADD;
                w_alu_src     = 1'b1;
                w_next_state  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_i_or_d     = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b0;
                w_mem_to_reg = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_i_or_d     = 1'b1;
                w_mem_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXEC_I: begin
                w_alu_control = ALU_ADD;
                w_alu_src     = 1'b1;
                w_next_state  = S_WB_I;
            end
            S_WB_I: begin
                w_reg_write  = !w_ovf_trap;
                w_reg_dst    = 1'b0;
                w_mem_to_reg = 1'b0;
                w_ovf_exc    = w_ovf_trap;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_pc_src = PC_BRANCH;
                if (opcode == OP_BNE) begin
                    w_alu_control = ALU_BNE;
                    w_pc_write    = ~Zero;
                end else begin
                    w_alu_control = ALU_BEQ;
                    w_pc_write    = Zero;
                end
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src     = PC_JUMP;
                w_pc_write   = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Drive outputs, holding every control low while reset is asserted so no write can slip out
    always_comb begin
        ALUControl = 4'b0000;
        ALUSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        IorD       = 1'b0;
        PCSrc      = 2'b00;
        ovf_exc    = 1'b0;
        if (rst_n) begin
            ALUControl = w_alu_control;
            ALUSrc     = w_alu_src;
            IRWrite    = w_ir_write;
            PCWrite    = w_pc_write;
            RegWrite   = w_reg_write;
            MemWrite   = w_mem_write;
            RegDst     = w_reg_dst;
            MemtoReg   = w_mem_to_reg;
            IorD       = w_i_or_d;
            PCSrc      = w_pc_src;
            ovf_exc    = w_ovf_exc;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control -- scoreboard bench for the multicycle control unit.
// Each instruction pushes its expected per-cycle control vector sequence;
// vectors are popped and compared on the falling edge.
module tb_mips_mc_control;

`ifdef OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       overflow;
    logic [3:0] ALUControl;
    logic       ALUSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       IorD;
    logic [1:0] PCSrc;
    logic       ovf_exc;

    int checks   = 0;
    int failures = 0;

    logic [14:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    mips_mc_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .Zero       (Zero),
        .overflow   (overflow),
        .ALUControl (ALUControl),
        .ALUSrc     (ALUSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .IorD       (IorD),
        .PCSrc      (PCSrc),
        .ovf_exc    (ovf_exc)
    );

    // Vector layout: {ALUControl, ALUSrc, IRWrite, PCWrite, RegWrite, MemWrite, RegDst, MemtoReg, IorD, PCSrc, ovf_exc}
    logic [14:0] w_obs;
    assign w_obs = {ALUControl, ALUSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                    RegDst, MemtoReg, IorD, PCSrc, ovf_exc};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] mk(input logic [3:0] alu, input logic src, input logic irw,
                                       input logic pcw, input logic rw, input logic mw,
                                       input logic rd, input logic m2r, input logic iord,
                                       input logic [1:0] pcs, input logic exc);
        return {alu, src, irw, pcw, rw, mw, rd, m2r, iord, pcs, exc};
    endfunction

    task automatic push(input string nm, input int idx, input logic [14:0] v);
        exp_q.push_back(v);
        tag_q.push_back($sformatf("%s_c%0d", nm, idx));
    endtask

    // Expected control sequence for one instruction, starting in FETCH
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input logic ov, input string nm);
        logic [3:0] alu;
        logic       fv;
        logic       hit;
        push(nm, 0, mk(4'b0000, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0));
        push(nm, 1, 15'd0);
        case (op)
            6'b000000: begin
                fv = 1'b1;
                case (fn)
                    6'b100000: alu = 4'b0000;
                    6'b100001: alu = 4'b0001;
                    6'b100010: alu = 4'b0010;
                    6'b100011: alu = 4'b0011;
                    6'b100100: alu = 4'b0100;
                    6'b100101: alu = 4'b0101;
                    6'b000000: alu = 4'b0110;
                    6'b000010: alu = 4'b0111;
                    6'b101010: alu = 4'b1000;
                    default: begin
                        alu = 4'b0000;
                        fv  = 1'b0;
                    end
                endcase
                hit = TRAP && ov && (alu == 4'b0000 || alu == 4'b0010);
                push(nm, 2, mk(alu, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
                push(nm, 3, mk(4'b0000, 0, 0, 0, fv && !hit, 0, 1, 0, 0, 2'b00, hit));
            end
            6'b100011: begin
                push(nm, 2, mk(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
                push(nm, 3, mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
                push(nm, 4, mk(4'b0000, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 0));
            end
            6'b101011: begin
                push(nm, 2, mk(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
                push(nm, 3, mk(4'b0000, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 0));
            end
            6'b001000: begin
                hit = TRAP && ov;
                push(nm, 2, mk(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
                push(nm, 3, mk(4'b0000, 0, 0, 0, !hit, 0, 0, 0, 0, 2'b00, hit));
            end
            6'b000100: push(nm, 2, mk(4'b1001, 0, 0, z, 0, 0, 0, 0, 0, 2'b01, 0));
            6'b000101: push(nm, 2, mk(4'b1010, 0, 0, !z, 0, 0, 0, 0, 0, 2'b01, 0));
            6'b000010: push(nm, 2, mk(4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 0));
            default: ;
        endcase
    endtask

    // One clock: compare at the falling edge, then advance just past the rising edge
    task automatic step_one();
        logic [14:0] e;
        string       t;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty observed=%h expected=none", w_obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, {17'd0, w_obs}, {17'd0, e});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic ov, input string nm);
        opcode   = op;
        funct    = fn;
        Zero     = z;
        overflow = ov;
        push_instr(op, fn, z, ov, nm);
        while (exp_q.size() > 0) step_one();
    endtask

    initial begin
        rst_n    = 1'b0;
        opcode   = 6'b100011;
        funct    = 6'b000000;
        Zero     = 1'b0;
        overflow = 1'b0;

        // Reset held: all outputs forced low
        push("reset", 0, 15'd0);
        push("reset", 1, 15'd0);
        while (exp_q.size() > 0) step_one();
        rst_n = 1'b1;

        run_instr(6'b000000, 6'b100000, 0, 0, "add");
        run_instr(6'b000000, 6'b100000, 0, 1, "add_ovf");
        run_instr(6'b000000, 6'b100010, 0, 1, "sub_ovf");
        run_instr(6'b000000, 6'b100011, 0, 1, "subu_ovf");
        run_instr(6'b000000, 6'b100001, 0, 0, "addu");
        run_instr(6'b000000, 6'b100100, 0, 0, "and");
        run_instr(6'b000000, 6'b100101, 0, 0, "or");
        run_instr(6'b000000, 6'b000000, 0, 0, "sll");
        run_instr(6'b000000, 6'b000010, 0, 0, "srl");
        run_instr(6'b000000, 6'b101010, 0, 0, "slt");
        run_instr(6'b000000, 6'b111111, 0, 0, "rbadfn");
        run_instr(6'b000100, 6'b000000, 1, 0, "beq_z1");
        run_instr(6'b000100, 6'b000000, 0, 0, "beq_z0");
        run_instr(6'b000101, 6'b000000, 1, 0, "bne_z1");
        run_instr(6'b000101, 6'b000000, 0, 0, "bne_z0");
        run_instr(6'b100011, 6'b000000, 0, 0, "lw");
        run_instr(6'b101011, 6'b000000, 0, 0, "sw");
        run_instr(6'b001000, 6'b000000, 0, 0, "addi");
        run_instr(6'b001000, 6'b000000, 0, 1, "addi_ovf");
        run_instr(6'b000010, 6'b000000, 0, 0, "j");
        run_instr(6'b111111, 6'b000000, 0, 0, "illegal");
        run_instr(6'b000000, 6'b100000, 0, 0, "add_after_ovf");

        // Reset during MEMRD: outputs forced low, instruction abandoned
        opcode = 6'b100011;
        push_instr(6'b100011, 6'b000000, 0, 0, "lw_rst");
        repeat (3) step_one();
        rst_n = 1'b0;
        exp_q.delete();
        tag_q.delete();
        push("rst_in_memrd", 0, 15'd0);
        step_one();
        rst_n = 1'b1;
        run_instr(6'b000010, 6'b000000, 0, 0, "j_after_rst");
        run_instr(6'b111111, 6'b000000, 0, 0, "illegal2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
